// File: rtl/fifo_mult_reader_if.sv
// fifo_mult_reader_if: FIFO read side and product handshake of the FIFO multiplier reader
interface fifo_mult_reader_if #(
  parameter int DATA_W = 16,
  parameter int LEFT_W = 3
);
  logic [LEFT_W-1:0]   left_sig;
  logic                read_req;
  logic [DATA_W-1:0]   fifo_read_data;
  logic [2*DATA_W-1:0] product;
  logic                product_valid;
  logic                out_ready;
  logic                busy;
  modport master (
    input  left_sig, fifo_read_data, out_ready,
    output read_req, product, product_valid, busy
  );
  modport slave (
    output left_sig, fifo_read_data, out_ready,
    input  read_req, product, product_valid, busy
  );
endinterface

// File: rtl/fifo_mult_reader.sv
// fifo_mult_reader: pops A/B operand pairs from a FIFO and multiplies them with a shift-add unit
module fifo_mult_reader #(
  parameter int DATA_W    = 16,
  parameter int FIFO_DEEP = 4,
  parameter int LEFT_W    = 3
) (
  input logic                clk,
  input logic                rst,
  fifo_mult_reader_if.master bus
);
  localparam int PW = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [LEFT_W:0] DEEP = (LEFT_W + 1)'(FIFO_DEEP);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, MUL, OUT} state_t;
  state_t            state_q, state_d;
  logic [PW-1:0]     a_q, a_d, acc_q, acc_d, prod_q, prod_d, sum;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LEFT_W:0]   left, occ;
  assign left = {1'b0, bus.left_sig};
  // out-of-range free-slot counts are treated as an empty FIFO
  assign occ = (left >= DEEP) ? '0 : DEEP - left;
  assign sum = acc_q + (b_q[0] ? a_q : '0);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE:  state_d = (occ >= (LEFT_W + 1)'(2)) ? RD_A : IDLE;
      RD_A:  state_d = RD_B;
      RD_B: begin
        a_d     = PW'(bus.fifo_read_data);
        state_d = CAP_B;
      end
      CAP_B: begin
        b_d     = bus.fifo_read_data;
        acc_d   = '0;
        cnt_d   = CW'(DATA_W);
        state_d = MUL;
      end
      MUL: begin
        acc_d   = sum;
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        prod_d  = (cnt_q == CW'(1)) ? sum : prod_q;
        state_d = (cnt_q == CW'(1)) ? OUT : MUL;
      end
      OUT:     state_d = bus.out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end
  assign bus.read_req      = (state_q == RD_A) || (state_q == RD_B);
  assign bus.product       = prod_q;
  assign bus.product_valid = state_q == OUT;
  assign bus.busy          = state_q != IDLE;
endmodule

// File: tb/tb_fifo_mult_reader.sv
// tb_fifo_mult_reader: directed checks of the FIFO multiplier reader against a small FIFO model
module tb_fifo_mult_reader;
  logic clk, rst;
  int errors = 0;
  int checks = 0;
  logic [15:0] q[$];
  logic ovr;
  logic [2:0] ovr_val;
  fifo_mult_reader_if #(.DATA_W(16), .LEFT_W(3)) bus ();
  fifo_mult_reader #(.DATA_W(16), .FIFO_DEEP(4), .LEFT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_comb bus.left_sig = ovr ? ovr_val : 3'(4 - q.size());
  always @(posedge clk)
    if (bus.read_req && q.size() > 0) bus.fifo_read_data <= q.pop_front();
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp, input string tag);
    int rr = 0;
    int early = 0;
    int busy_lo = 0;
    @(negedge clk);
    q.push_back(a);
    q.push_back(b);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.read_req) rr++;
      if (!bus.busy) busy_lo++;
      if (c < 20 && bus.product_valid) early++;
    end
    check({tag, " reads"}, 32'(rr), 32'd2);
    check({tag, " early_valid"}, 32'(early), 32'd0);
    check({tag, " busy"}, 32'(busy_lo), 32'd0);
    check({tag, " valid"}, {31'd0, bus.product_valid}, 32'd1);
    check({tag, " product"}, bus.product, exp);
    @(negedge clk);
    check({tag, " pulse"}, {31'd0, bus.product_valid}, 32'd0);
  endtask
  initial begin
    int bad, rr, n;
    rst = 1'b1;
    ovr = 1'b0;
    ovr_val = '0;
    bus.out_ready = 1'b1;
    bus.fifo_read_data = '0;
    repeat (3) @(negedge clk);
    check("rst read_req", {31'd0, bus.read_req}, 32'd0);
    check("rst valid", {31'd0, bus.product_valid}, 32'd0);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst product", bus.product, 32'd0);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.read_req) bad++;
    end
    check("empty no read", 32'(bad), 32'd0);
    ovr = 1'b1;
    ovr_val = 3'd3;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.read_req || bus.busy) bad++;
    end
    check("occ1 no read", 32'(bad), 32'd0);
    bad = 0;
    for (int v = 5; v <= 7; v++) begin
      ovr_val = 3'(v);
      repeat (10) begin
        @(negedge clk);
        if (bus.read_req || bus.busy) bad++;
      end
    end
    check("out_of_range no read", 32'(bad), 32'd0);
    ovr = 1'b0;
    run_pair(16'd3, 16'd5, 32'd15, "p3x5");
    run_pair(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "pmax");
    run_pair(16'h0000, 16'h1234, 32'h0, "pzero");
    run_pair(16'h8000, 16'h0002, 32'h00010000, "pmsb");
    @(negedge clk);
    bus.out_ready = 1'b0;
    q.push_back(16'd3);
    q.push_back(16'd5);
    q.push_back(16'd7);
    q.push_back(16'd9);
    repeat (20) @(negedge clk);
    check("bp first valid", {31'd0, bus.product_valid}, 32'd1);
    check("bp first product", bus.product, 32'd15);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.product_valid || bus.product !== 32'd15 || bus.read_req) bad++;
    end
    check("bp stall hold", 32'(bad), 32'd0);
    bus.out_ready = 1'b1;
    rr = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (bus.read_req) rr++;
      n++;
    end while (!(bus.product_valid && n > 1) && n < 40);
    check("bp second valid", {31'd0, bus.product_valid}, 32'd1);
    check("bp second product", bus.product, 32'd63);
    check("bp second reads", 32'(rr), 32'd2);
    check("bp queue drained", 32'(q.size()), 32'd0);
    @(negedge clk);
    q.push_back(16'd3);
    q.push_back(16'd5);
    repeat (10) @(negedge clk);
    check("mid busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("async busy", {31'd0, bus.busy}, 32'd0);
    check("async read_req", {31'd0, bus.read_req}, 32'd0);
    check("async valid", {31'd0, bus.product_valid}, 32'd0);
    check("async product", bus.product, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_pair(16'd2, 16'd4, 32'd8, "post_rst");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_mult_reader.md
Name: fifo_mult_reader

Overview:
Consumer end of the 16-bit synchronous FIFO in the FIFO-multiplier datapath. It watches the FIFO's free-slot count and pops operand pairs (A, then B) with single-cycle read requests. It multiplies each pair as unsigned values using a sequential shift-add unit, one bit per cycle. It presents the 32-bit product to downstream logic with a valid/ready handshake.

Parameters:
DATA_W, 16, operand width; equals the FIFO data width
FIFO_DEEP, 4, FIFO capacity; used to derive occupancy from left_sig
LEFT_W, 3, width of left_sig

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
left_sig  input  LEFT_W  FIFO free slots; occupancy = FIFO_DEEP - left_sig
read_req  output  1  FIFO pop request; one word per cycle asserted
fifo_read_data  input  DATA_W  FIFO output word; holds the popped word the cycle after read_req
product  output  2*DATA_W  A*B, unsigned
product_valid  output  1  product is valid; held until accepted
out_ready  input  1  downstream accepts product when high with product_valid
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: rst is asynchronous and active-high. While rst is high, all registers clear immediately: state=IDLE, read_req=0, product=0, product_valid=0, busy=0, operand registers and counter=0.
- Occupancy: occ = (left_sig >= FIFO_DEEP) ? 0 : FIFO_DEEP - left_sig. Out-of-range left_sig (>FIFO_DEEP) counts as empty.
- read_req is a registered output, decoded from the state register. It is high only in RD_A and RD_B.
- FIFO read latency is one cycle. The word popped by read_req in cycle n is on fifo_read_data in cycle n+1 and is sampled at the end of that cycle.
- State machine:
  IDLE: if occ >= 2 -> RD_A; else stay. A pair is started only when both words are present, so a pair never stalls mid-read.
  RD_A: read_req=1 -> RD_B.
  RD_B: read_req=1; capture A <= fifo_read_data -> CAP_B.
  CAP_B: read_req=0; capture B <= fifo_read_data; clear accumulator; load bit counter=DATA_W -> MUL.
  MUL: each cycle, if B[0] then acc <= acc + A_ext. Then A_ext <<= 1, B >>= 1, counter--. When the counter reaches 0 (after exactly DATA_W cycles), product <= acc -> OUT.
  OUT: product_valid=1. If out_ready is high, the handshake completes this cycle -> IDLE, and product_valid drops next cycle. Otherwise stay in OUT, with product and product_valid held stable.
- Arithmetic: unsigned only. A_ext and acc are 2*DATA_W bits wide, and the product is exact with no truncation.
- Latency: let cycle 0 be the IDLE cycle in which occ >= 2.
  - read_req is high in cycles 1-2.
  - MUL runs in cycles 4..3+DATA_W.
  - product_valid rises in cycle 4+DATA_W (cycle 20 at default).
  - With out_ready constantly high, the earliest next RD_A is cycle 6+DATA_W.
- Exactly two pops per pair. No read_req is issued in CAP_B, MUL or OUT, whatever occ is. This block is the FIFO's only reader.
- Concurrent FIFO writes during any state are legal. occ is sampled only in IDLE.
- Backpressure: while in OUT, the block issues no reads, so the FIFO may fill. Upstream must honour left_sig==0.
- Reset mid-operation: a partial pair is discarded, and words already popped are lost. After rst falls, the block restarts from IDLE and re-evaluates occ.
- busy=1 from RD_A through OUT inclusive.

Test Plan:
1. Assert rst for 3 cycles, then release with left_sig=4 -> read_req, product_valid, busy and product all 0; no read_req for 20 cycles.
2. Hold left_sig=3 (occ=1) for 50 cycles -> read_req never asserted; busy stays 0.
3. FIFO model preloaded with 16'd3, 16'd5 (left_sig=2), out_ready=1 -> read_req high exactly 2 cycles; product=32'd15 with product_valid in cycle 20; one-cycle pulse.
4. Operands 16'hFFFF and 16'hFFFF -> product=32'hFFFE0001. Operands 16'h0000 and 16'h1234 -> product=32'h0. Operands 16'h8000 and 16'h0002 -> product=32'h00010000.
5. Four words queued (3,5,7,9) with out_ready low for 10 cycles after the first product_valid:
   - product stays 32'd15 and valid stays high;
   - no read_req during the stall;
   - after acceptance, the second pair yields 32'd63.
6. Pulse rst for 1 cycle during MUL (cycle 10) -> product_valid, read_req and busy go 0 immediately. With left_sig=2 and words 2,4 then supplied, product=32'd8.
